lcd_bus_monitor: RTL and testbench
==================================

Name: lcd_bus_monitor

Overview:
- Listening end of the HD44780-style LCD write bus (data[7:0], lcd_e, lcd_rs, lcd_rw) driven by the LCD interface block.
- Decodes command and data writes and maintains a 32-character shadow of the 2x16 display.
- Exposes the shadow, cursor and display state for on-chip readback and for bench checking of LCD traffic.
- Sits beside the LCD pins, clocked from the 4 MHz PLL output, which oversamples the 1 MHz-domain LCD strobes.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on all bus inputs; legal values 2..3.
- BLANK_CHAR, 8'h20, fill value after reset and after Clear Display.

Ports:
- clk_4MHz  input  1  sampling clock.
- rst  input  1  asynchronous, active-high reset.
- data  input  8  LCD data bus.
- lcd_e  input  1  LCD enable; write is latched on its falling edge.
- lcd_rs  input  1  0 = command, 1 = data.
- lcd_rw  input  1  0 = write, 1 = read.
- rd_addr  input  5  shadow index: 0-15 is line 1, 16-31 is line 2.
- rd_char  output  8  shadow[rd_addr], registered.
- cursor_addr  output  7  current DDRAM address counter.
- display_on  output  1  last Display Control D bit.
- cursor_on  output  1  last Display Control C bit.
- busy  output  1  high while a Clear Display fill is in progress.
- write_strobe  output  1  one-cycle pulse when a visible character is stored.
- cmd_strobe  output  1  one-cycle pulse when a command is applied.
- err_overrun  output  1  sticky flag: a bus event was dropped.
- err_count  output  8  dropped-event count (see Optional Feature).

Behaviour:
- Reset: all shadow entries = BLANK_CHAR; address counter = 0; ID = 1; display_on = cursor_on = busy = 0; strobes = 0; err_overrun = 0; rd_char = BLANK_CHAR.
- Input capture: data, lcd_rs, lcd_rw and lcd_e pass through SYNC_STAGES flops. An event is a 1-to-0 transition of synchronized lcd_e. The event uses the synchronized data, rs and rw from the same stage.
- Latency: with SYNC_STAGES = 2, the state update and strobe occur 3 clk_4MHz cycles after the lcd_e falling edge at the pin.
- Events with rw = 1: ignored; no state change, no strobe, not counted as an error.
- Data write (rs = 1):
  - Address visible (addr[5:4] == 0): shadow[{addr[6], addr[3:0]}] = data; write_strobe pulses.
  - Address not visible: character discarded; no strobe.
  - Either case: address counter then steps by ID.
- Command write (rs = 0): priority decode on the highest set bit; cmd_strobe pulses once.
  - bit7, Set DDRAM: addr = data[6:0].
  - bit6, Set CGRAM: no effect.
  - bit5, Function Set: no effect.
  - bit4, Cursor/Display Shift: no effect.
  - bit3, Display Control: display_on = data[2]; cursor_on = data[1].
  - bit2, Entry Mode: ID = data[1].
  - bit1, Return Home: addr = 0.
  - bit0, Clear Display: addr = 0; ID = 1; enter CLEAR state.
  - data = 0x00: no effect, and cmd_strobe still pulses.
- Address stepping:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x40 -> 0x27, 0x00 -> 0x67.
  - Other addresses step by ±1 within the 7-bit space. Values 0x28-0x3F and 0x68-0x7F are set only by Set DDRAM.
- State machine:
  - IDLE -> CLEAR on a Clear Display command.
  - CLEAR writes BLANK_CHAR to one index per cycle, 0..31, with busy = 1.
  - CLEAR -> IDLE after index 31 is written; busy falls on the following cycle (32 cycles high).
- Events during CLEAR are dropped and set err_overrun. A second Clear Display during CLEAR is also dropped.
- rd_char: registered read of shadow[rd_addr], 1-cycle latency. During CLEAR it returns the current, partially cleared contents.
- Reset asserted mid-operation (including during CLEAR) immediately restores all reset values.

Optional Feature:
- Macro: LCDMON_ERRCNT_EN.
- Defined: err_count is an 8-bit counter incremented on each dropped event, saturating at 0xFF and cleared only by rst.
- Undefined: err_count is tied to 8'h00 and the counter logic is absent. err_overrun behaves identically in both builds.

Test Plan:
- Reset, then write data 0x41 (rs = 1) -> write_strobe pulses 3 cycles after the lcd_e fall; rd_addr = 0 gives rd_char = 0x41; cursor_addr = 0x01.
- Command 0xC0, then data 0x42 -> shadow[16] = 0x42; cursor_addr = 0x41.
- Command 0xA7 (addr 0x27), then data 0x43 -> shadow unchanged; no write_strobe; cursor_addr = 0x40.
- Command 0x04 (decrement), command 0x80, then data 0x44 -> shadow[0] = 0x44; cursor_addr = 0x67.
- Fill several characters, then command 0x01 -> busy high exactly 32 cycles; all entries read 0x20; cursor_addr = 0; ID = 1.
- Data write during busy -> dropped; err_overrun = 1; err_count = 1 with LCDMON_ERRCNT_EN defined, 0 without. Assert rst mid-CLEAR -> all outputs return to reset values.

Source files
------------

// File: rtl/lcd_bus_monitor.sv
// Passive monitor for an HD44780-style LCD write bus: keeps a 2x16 character shadow plus cursor/display state.
// Build option: define LCDMON_ERRCNT_EN to get a saturating dropped-event counter on err_count.
module lcd_bus_monitor #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic       clk_4MHz,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       busy,
  output logic       write_strobe,
  output logic       cmd_strobe,
  output logic       err_overrun,
  output logic [7:0] err_count
);

  localparam int LAST = SYNC_STAGES - 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  logic [SYNC_STAGES-1:0]      e_sync_q, rs_sync_q, rw_sync_q;
  logic [SYNC_STAGES-1:0][7:0] data_sync_q;
  logic                        e_last_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would collapse the sync chain.
  always_ff @(posedge clk_4MHz or posedge rst) begin
    if (rst) begin
      e_sync_q    <= '0;
      rs_sync_q   <= '0;
      rw_sync_q   <= '0;
      data_sync_q <= '0;
      e_last_q    <= 1'b0;
    end else begin
      e_sync_q    <= {e_sync_q[SYNC_STAGES-2:0], lcd_e};
      rs_sync_q   <= {rs_sync_q[SYNC_STAGES-2:0], lcd_rs};
      rw_sync_q   <= {rw_sync_q[SYNC_STAGES-2:0], lcd_rw};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data};
      e_last_q    <= e_sync_q[LAST];
    end
  end

  logic       bus_event;
  logic       rs_s;
  logic [7:0] data_s;

  // Reads (rw = 1) are not events at all, so they can never count as drops.
  assign bus_event = e_last_q & ~e_sync_q[LAST] & ~rw_sync_q[LAST];
  assign rs_s      = rs_sync_q[LAST];
  assign data_s    = data_sync_q[LAST];

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    if (inc) begin
      case (a)
        7'h27:   return 7'h40;
        7'h67:   return 7'h00;
        default: return a + 7'd1;
      endcase
    end else begin
      case (a)
        7'h40:   return 7'h27;
        7'h00:   return 7'h67;
        default: return a - 7'd1;
      endcase
    end
  endfunction

  state_t     state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic       id_q, id_d;
  logic       disp_q, disp_d;
  logic       cur_q, cur_d;
  logic [4:0] clr_idx_q, clr_idx_d;
  logic       ws_q, ws_d;
  logic       cs_q, cs_d;
  logic       err_q, err_d;
  logic       drop;
  logic       sh_we;
  logic [4:0] sh_idx;
  logic [7:0] sh_wdata;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    id_d      = id_q;
    disp_d    = disp_q;
    cur_d     = cur_q;
    clr_idx_d = clr_idx_q;
    ws_d      = 1'b0;
    cs_d      = 1'b0;
    drop      = 1'b0;
    sh_we     = 1'b0;
    sh_idx    = '0;
    sh_wdata  = BLANK_CHAR;

    case (state_q)
      ST_IDLE: begin
        if (bus_event) begin
          if (rs_s) begin
            if (addr_q[5:4] == 2'b00) begin
              sh_we    = 1'b1;
              sh_idx   = {addr_q[6], addr_q[3:0]};
              sh_wdata = data_s;
              ws_d     = 1'b1;
            end
            addr_d = step_addr(addr_q, id_q);
          end else begin
            cs_d = 1'b1;
            casez (data_s)
              8'b1???????: addr_d = data_s[6:0];
              8'b01??????,
              8'b001?????,
              8'b0001????: ;
              8'b00001???: begin
                disp_d = data_s[2];
                cur_d  = data_s[1];
              end
              8'b000001??: id_d = data_s[1];
              8'b0000001?: addr_d = '0;
              8'b00000001: begin
                addr_d    = '0;
                id_d      = 1'b1;
                clr_idx_d = '0;
                state_d   = ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        sh_we     = 1'b1;
        sh_idx    = clr_idx_q;
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'd31) state_d = ST_IDLE;
        drop = bus_event;
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = err_q | drop;
  end

  always_ff @(posedge clk_4MHz or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      id_q      <= 1'b1;
      disp_q    <= 1'b0;
      cur_q     <= 1'b0;
      clr_idx_q <= '0;
      ws_q      <= 1'b0;
      cs_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      disp_q    <= disp_d;
      cur_q     <= cur_d;
      clr_idx_q <= clr_idx_d;
      ws_q      <= ws_d;
      cs_q      <= cs_d;
      err_q     <= err_d;
    end
  end

  logic [7:0] shadow_q [32];
  logic [7:0] rd_char_q;

  // NOTE: the shadow is a flop array with async reset, not RAM, because reset must show a blank display at once.
  always_ff @(posedge clk_4MHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= BLANK_CHAR;
      rd_char_q <= BLANK_CHAR;
    end else begin
      if (sh_we) shadow_q[sh_idx] <= sh_wdata;
      rd_char_q <= shadow_q[rd_addr];
    end
  end

`ifdef LCDMON_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_4MHz or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (drop && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

  assign rd_char      = rd_char_q;
  assign cursor_addr  = addr_q;
  assign display_on   = disp_q;
  assign cursor_on    = cur_q;
  assign busy         = (state_q == ST_CLEAR);
  assign write_strobe = ws_q;
  assign cmd_strobe   = cs_q;
  assign err_overrun  = err_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Bench for lcd_bus_monitor: directed plan steps, then random bus traffic against an arithmetic display model.
`timescale 1ns/1ps
module tb_lcd_bus_monitor;

  logic       clk_4MHz = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] data     = 8'h00;
  logic       lcd_e    = 1'b0;
  logic       lcd_rs   = 1'b0;
  logic       lcd_rw   = 1'b0;
  logic [4:0] rd_addr  = 5'd0;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, busy, write_strobe, cmd_strobe, err_overrun;
  logic [7:0] err_count;

  lcd_bus_monitor dut (
    .clk_4MHz    (clk_4MHz),
    .rst         (rst),
    .data        (data),
    .lcd_e       (lcd_e),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .cursor_addr (cursor_addr),
    .display_on  (display_on),
    .cursor_on   (cursor_on),
    .busy        (busy),
    .write_strobe(write_strobe),
    .cmd_strobe  (cmd_strobe),
    .err_overrun (err_overrun),
    .err_count   (err_count)
  );

  always #125 clk_4MHz = ~clk_4MHz;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Model of the display as the LCD user sees it.
  logic [7:0] m_shadow [32];
  int         m_addr;
  bit         m_inc, m_disp, m_cur, m_err, m_busy;
  int         m_errcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_step(input int a, input bit inc);
    if (inc) begin
      if (a == 39)  return 64;
      if (a == 103) return 0;
      return (a + 1) % 128;
    end
    if (a == 64) return 39;
    if (a == 0)  return 103;
    return (a + 127) % 128;
  endfunction

  function automatic bit m_visible(input int a);
    return (a % 64) < 16;
  endfunction

  function automatic int m_index(input int a);
    return (a >= 64 ? 16 : 0) + (a % 16);
  endfunction

  function automatic int exp_errcnt();
`ifdef LCDMON_ERRCNT_EN
    return m_errcnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
    m_addr = 0; m_inc = 1; m_disp = 0; m_cur = 0; m_err = 0; m_errcnt = 0; m_busy = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, " cursor_addr"}, cursor_addr, m_addr);
    check({tag, " display_on"},  display_on,  m_disp);
    check({tag, " cursor_on"},   cursor_on,   m_cur);
    check({tag, " err_overrun"}, err_overrun, m_err);
    check({tag, " err_count"},   err_count,   exp_errcnt());
  endtask

  task automatic read_at(input int idx);
    @(negedge clk_4MHz) rd_addr = idx[4:0];
    @(negedge clk_4MHz) check($sformatf("rd_char[%0d]", idx), rd_char, m_shadow[idx]);
  endtask

  task automatic scan_all();
    for (int i = 0; i < 32; i++) read_at(i);
  endtask

  // Drives one bus cycle, predicts its effect, and checks strobe timing relative to the lcd_e fall.
  task automatic do_event(input bit rs, input bit rw, input logic [7:0] d, input bit wait_clear);
    bit         exp_ws = 0, exp_cs = 0, is_clear = 0;
    logic [3:0] ws_mask = '0, cs_mask = '0;
    int         bcnt = 0;
    if (!rw) begin
      if (m_busy) begin
        m_err = 1;
        if (m_errcnt < 255) m_errcnt++;
      end else if (rs) begin
        if (m_visible(m_addr)) begin
          m_shadow[m_index(m_addr)] = d;
          exp_ws = 1;
        end
        m_addr = m_step(m_addr, m_inc);
      end else begin
        exp_cs = 1;
        if (d >= 128)     m_addr = d - 128;
        else if (d >= 16) ;
        else if (d >= 8)  begin m_disp = d[2]; m_cur = d[1]; end
        else if (d >= 4)  m_inc = d[1];
        else if (d >= 2)  m_addr = 0;
        else if (d == 1)  begin
          m_addr = 0; m_inc = 1; is_clear = 1;
          for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
        end
      end
    end
    @(negedge clk_4MHz);
    data = d; lcd_rs = rs; lcd_rw = rw; lcd_e = 1'b1;
    repeat (3) @(negedge clk_4MHz);
    lcd_e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_4MHz);
      ws_mask[i] = write_strobe;
      cs_mask[i] = cmd_strobe;
      if (busy && i >= 2) bcnt++;
    end
    check($sformatf("write_strobe rs=%0d rw=%0d d=%02h", rs, rw, d), ws_mask, {1'b0, exp_ws, 2'b00});
    check($sformatf("cmd_strobe rs=%0d rw=%0d d=%02h", rs, rw, d),   cs_mask, {1'b0, exp_cs, 2'b00});
    if (is_clear && wait_clear) begin
      while (busy && bcnt < 100) begin
        @(negedge clk_4MHz);
        if (busy) bcnt++;
      end
      check("busy_cycles", bcnt, 32);
    end else if (is_clear) begin
      m_busy = 1;
    end
    check_state($sformatf("after d=%02h", d));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk_4MHz);
      n++;
    end
    check("busy_fell", busy, 1'b0);
    m_busy = 0;
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] near_tbl [8];
    bit         rs, rw;
    int         r;
    near_tbl = '{8'h26, 8'h27, 8'h66, 8'h67, 8'h40, 8'h00, 8'h0F, 8'h4F};

    model_reset();
    repeat (3) @(negedge clk_4MHz);
    check("reset rd_char", rd_char, 8'h20);
    check("reset busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk_4MHz);
    check("reset strobes", {write_strobe, cmd_strobe}, 2'b00);
    check("reset busy after release", busy, 1'b0);
    check_state("reset");

    // Plan step 1..4
    do_event(1, 0, 8'h41, 1);
    read_at(0);
    check("tp1 cursor", cursor_addr, 7'h01);
    do_event(0, 0, 8'hC0, 1);
    do_event(1, 0, 8'h42, 1);
    read_at(16);
    check("tp2 cursor", cursor_addr, 7'h41);
    do_event(0, 0, 8'hA7, 1);
    do_event(1, 0, 8'h43, 1);
    check("tp3 cursor", cursor_addr, 7'h40);
    scan_all();
    do_event(0, 0, 8'h04, 1);
    do_event(0, 0, 8'h80, 1);
    do_event(1, 0, 8'h44, 1);
    read_at(0);
    check("tp4 cursor", cursor_addr, 7'h67);

    // Read cycles and a display-control command, then fill and clear.
    do_event(1, 1, 8'h99, 1);
    do_event(0, 0, 8'h0E, 1);
    do_event(0, 0, 8'h06, 1);
    do_event(0, 0, 8'h8E, 1);
    for (int i = 0; i < 5; i++) do_event(1, 0, 8'h61 + i, 1);
    scan_all();
    do_event(0, 0, 8'h01, 1);
    check("tp5 cursor", cursor_addr, 7'h00);
    scan_all();
    do_event(1, 0, 8'h50, 1);
    check("tp5 id=1", cursor_addr, 7'h01);

    // Events during CLEAR are dropped, including a second clear.
    do_event(0, 0, 8'h01, 0);
    do_event(1, 0, 8'h55, 0);
    check("drop err_overrun", err_overrun, 1'b1);
    do_event(0, 0, 8'h01, 0);
    wait_idle();
    check_state("after drops");
    scan_all();

    // Random traffic biased toward the wrap addresses.
    for (int n = 0; n < 120; n++) begin
      r  = $urandom_range(0, 99);
      rw = (r < 8);
      rs = $urandom_range(0, 1);
      d  = 8'($urandom);
      if (!rs) begin
        case ($urandom_range(0, 9))
          0:       d = 8'h01;
          1:       d = 8'h04 | (d & 8'h03);
          2:       d = 8'h08 | (d & 8'h07);
          3, 4:    d = 8'h80 | near_tbl[$urandom_range(0, 7)];
          5:       d = 8'h02 | (d & 8'h01);
          default: ;
        endcase
      end
      do_event(rs, rw, d, 1);
      if (n % 30 == 29) scan_all();
    end

    // Reset in the middle of a clear restores everything immediately.
    do_event(0, 0, 8'h0C, 1);
    do_event(1, 0, 8'h5A, 1);
    do_event(0, 0, 8'h01, 0);
    do_event(1, 0, 8'h33, 0);
    repeat (3) @(negedge clk_4MHz);
    rst = 1'b1;
    #10;
    model_reset();
    check("midclear busy", busy, 1'b0);
    check("midclear rd_char", rd_char, 8'h20);
    check("midclear strobes", {write_strobe, cmd_strobe}, 2'b00);
    check_state("midclear reset");
    @(negedge clk_4MHz) rst = 1'b0;
    scan_all();
    do_event(1, 0, 8'h77, 1);
    read_at(0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
